// File: rtl/viterbi_traceback.sv
// Viterbi traceback: buffers survivor columns, walks the best path
// backwards, then emits the decoded frame first-received-first.
module viterbi_traceback #(
  parameter int ST_W   = 8,
  parameter int NUM_ST = 2**ST_W,
  parameter int TB_LEN = 16,
  parameter int CW     = $clog2(TB_LEN)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_tb,
  input  logic [NUM_ST-1:0][ST_W-1:0]      i_fwd_nxt_st,
  input  logic [ST_W-1:0]                  i_sel_node,
  output logic                             o_ready,
  output logic                             o_bit,
  output logic                             o_bit_valid,
  output logic                             o_frame_done
);

  typedef enum logic [1:0] {
    WRITE,
    TRACE,
    OUT
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(TB_LEN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [ST_W-1:0]   cur_st_q, cur_st_d;
  logic              mem_we;
  logic              bit_we;

  logic [NUM_ST-1:0][ST_W-1:0] surv_mem [TB_LEN];
  logic [TB_LEN-1:0]           bit_buf;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    cur_st_d     = cur_st_q;
    mem_we       = 1'b0;
    bit_we       = 1'b0;
    o_frame_done = 1'b0;
    unique case (state_q)
      WRITE: begin
        if (en_tb) begin
          mem_we = 1'b1;
          if (wr_cnt_q == LAST) begin
            cur_st_d = i_sel_node;
            ptr_d    = LAST;
            wr_cnt_d = '0;
            state_d  = TRACE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      TRACE: begin
        bit_we   = 1'b1;
        cur_st_d = surv_mem[ptr_q][cur_st_q];
        if (ptr_q == '0) begin
          idx_d   = '0;
          state_d = OUT;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      OUT: begin
        if (idx_q == LAST) begin
          o_frame_done = 1'b1;
          state_d      = WRITE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WRITE;
      wr_cnt_q <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      cur_st_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cur_st_q <= cur_st_d;
    end
  end

  // Frame storage carries no reset; an aborted frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (mem_we) surv_mem[wr_cnt_q] <= i_fwd_nxt_st;
    if (bit_we) bit_buf[ptr_q] <= cur_st_q[ST_W-1];
  end

  assign o_ready     = (state_q == WRITE);
  assign o_bit_valid = (state_q == OUT);
  assign o_bit       = (state_q == OUT) & bit_buf[idx_q];

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomized scoreboard bench for viterbi_traceback.
// Expected bits come from a plain array walk over the stored columns.
module tb_viterbi_traceback;

  localparam int ST_W   = 8;
  localparam int NUM_ST = 256;
  localparam int TB_LEN = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_tb = 1'b0;
  logic [NUM_ST-1:0][ST_W-1:0] fwd = '0;
  logic [ST_W-1:0] i_sel_node = '0;
  logic o_ready, o_bit, o_bit_valid, o_frame_done;

  viterbi_traceback #(.ST_W(ST_W), .NUM_ST(NUM_ST), .TB_LEN(TB_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_tb        (en_tb),
    .i_fwd_nxt_st (fwd),
    .i_sel_node   (i_sel_node),
    .o_ready      (o_ready),
    .o_bit        (o_bit),
    .o_bit_valid  (o_bit_valid),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit b;
    bit last;
    int at;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] col [TB_LEN][NUM_ST];

  function automatic void chk(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", n, a, e, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (o_frame_done) chk("done_needs_valid", int'(o_bit_valid), 1);
      if (o_bit_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_bit", sbq.size(), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("bit", int'(o_bit), int'(e.b));
          chk("frame_done", int'(o_frame_done), int'(e.last));
          chk("bit_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic rand_inputs();
    for (int s = 0; s < NUM_ST; s++) fwd[s] = 8'($urandom);
    i_sel_node = 8'($urandom);
  endtask

  // mode 0: random columns, 1: all-zero, 2: known encoder path
  task automatic run_frame(input int mode, input bit gap,
                           input bit junk, input bit abort);
    int acc, a_cyc, it;
    logic [7:0] sel, cur, sv;
    logic [15:0] msg;
    bit eb [TB_LEN];
    bit en;
    msg = 16'hA5C3;
    acc = 0;
    it = 0;
    a_cyc = 0;
    sel = '0;
    while (acc < TB_LEN && it < 200) begin
      en = gap ? (it[0] == 1'b0) : 1'b1;
      rand_inputs();
      if (en && o_ready) begin
        for (int s = 0; s < NUM_ST; s++) begin
          sv = 8'(s);
          if (mode == 1) col[acc][s] = '0;
          else if (mode == 2)
            col[acc][s] = {sv[6:0], (acc >= 8) ? msg[acc-8] : 1'b0};
          else col[acc][s] = fwd[s];
          fwd[s] = col[acc][s];
        end
        if (acc == TB_LEN - 1) begin
          if (mode == 1) sel = '0;
          else if (mode == 2) sel = msg[15:8];
          else sel = 8'($urandom);
          i_sel_node = sel;
          a_cyc = cyc + 1;
        end
        acc++;
      end
      en_tb = en;
      it++;
      @(negedge clk);
    end
    chk("accepts", acc, TB_LEN);
    cur = sel;
    for (int k = TB_LEN - 1; k >= 0; k--) begin
      if (mode == 1) eb[k] = 1'b0;
      else if (mode == 2) eb[k] = msg[k];
      else eb[k] = cur[7];
      cur = col[k][cur];
    end
    for (int k = 0; k < TB_LEN; k++)
      sbq.push_back('{b: eb[k], last: (k == TB_LEN - 1),
                      at: a_cyc + TB_LEN + k});
    if (abort) begin
      en_tb = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_ready", int'(o_ready), 1);
      chk("abort_valid", int'(o_bit_valid), 0);
      chk("abort_done", int'(o_frame_done), 0);
      sbq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      return;
    end
    it = 0;
    while (!o_ready && it < 100) begin
      en_tb = junk;
      if (junk) rand_inputs();
      it++;
      @(negedge clk);
    end
    chk("ready_return", cyc, a_cyc + 2 * TB_LEN);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_bit", int'(o_bit), 0);
    chk("rst_valid", int'(o_bit_valid), 0);
    chk("rst_done", int'(o_frame_done), 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(1, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 1'b1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b1, 1'b0);
    en_tb = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback stage of the Viterbi decoder, directly downstream of the add-compare-select stage. Each accepted step, it stores one column of per-state survivor predecessors into a frame buffer. After TB_LEN columns it walks the survivor path backwards from the ACS-selected best node. It then emits the decoded frame bit-serially in original (first-received-first) order.

## Interface
- ST_W, 8, state index width (matches ACS survivor and selected-node width)
- NUM_ST, 2**ST_W, number of trellis states (256)
- TB_LEN, 16, steps per frame (traceback depth), ≥2
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-low reset
- en_tb  input  1  column valid from ACS; accepted only when o_ready=1
- i_fwd_nxt_st  input  NUM_ST×ST_W  survivor column; entry [s] = predecessor state of state s at this step
- i_sel_node  input  ST_W  ACS best-metric state; sampled only on the accept cycle of the last column of a frame
- o_ready  output  1  block accepts columns (state WRITE)
- o_bit  output  1  decoded bit
- o_bit_valid  output  1  o_bit is valid this cycle
- o_frame_done  output  1  one-cycle pulse coincident with the last decoded bit of a frame

## Operation
- Storage: surv_mem[TB_LEN][NUM_ST] of ST_W bits; bit_buf[TB_LEN] of 1 bit; wr_cnt, ptr and idx counters are ceil(log2(TB_LEN)) bits; cur_st is ST_W bits.
- FSM states: WRITE, TRACE, OUT. Reset state is WRITE.
- WRITE:
  - On accept (en_tb & o_ready): surv_mem[wr_cnt] <= i_fwd_nxt_st.
  - If wr_cnt = TB_LEN-1: cur_st <= i_sel_node, ptr <= TB_LEN-1, wr_cnt <= 0, go to TRACE.
  - Otherwise wr_cnt <= wr_cnt+1.
  - en_tb low: hold all state.
- TRACE, one step per cycle:
  - bit_buf[ptr] <= cur_st[ST_W-1]. The decoded bit of a step is the MSB of the state entered at that step.
  - cur_st <= surv_mem[ptr][cur_st].
  - If ptr = 0: idx <= 0, go to OUT. Otherwise ptr <= ptr-1.
- OUT:
  - o_bit = bit_buf[idx], o_bit_valid = 1.
  - If idx = TB_LEN-1: o_frame_done = 1, go to WRITE. Otherwise idx <= idx+1.
- o_ready = (state==WRITE); o_bit_valid = (state==OUT). Both are decoded from registers only, with no combinational path from inputs.
- en_tb, i_fwd_nxt_st and i_sel_node are ignored in TRACE and OUT. The upstream stage must stall on o_ready=0. Columns presented then are dropped, not queued.
- Predecessor entries are used as-is; no range check is needed since every ST_W-bit value is a legal state.
- Reset (any time, including mid-frame): FSM returns to WRITE, wr_cnt/ptr/idx/cur_st are cleared, and the partial frame is discarded. surv_mem and bit_buf contents need not be cleared.

## Timing
- Reset values: o_ready=1, o_bit=0, o_bit_valid=0, o_frame_done=0.
- If the last column of a frame is accepted in cycle T:
  - TRACE occupies cycles T+1 … T+TB_LEN.
  - OUT occupies cycles T+TB_LEN+1 … T+2·TB_LEN; the bit for step k appears at T+TB_LEN+1+k.
  - o_frame_done is high in cycle T+2·TB_LEN.
  - o_ready rises in T+2·TB_LEN+1, and a new first column may be accepted in that same cycle.
- Per-frame occupancy: TB_LEN accept cycles (minimum) plus 2·TB_LEN busy cycles. With defaults, 16 input columns produce 16 bits every ≥48 cycles.
- Gaps in en_tb during WRITE stretch only the WRITE phase. The TRACE and OUT durations are fixed.
- Simultaneous: en_tb high in the cycle o_ready first returns is a legal accept. en_tb high in the o_frame_done cycle is not accepted.

## Test plan
- Reset: assert rst=0 mid-TRACE. Required: o_ready=1 and o_bit_valid=0 immediately (asynchronously). After release, a fresh frame of 16 columns decodes correctly, with no bits from the aborted frame.
- All-zero survivors: 16 columns with every entry 0, i_sel_node=0x00. Required: 16 valid bits all 0, o_frame_done on the 16th bit, first bit at T+17.
- Known path: reference model encodes message 0xA5C3 (bit0 first) through a shift-register trellis (state = {new_bit, prev[7:1]}). Build columns so that pred(s) = {s[6:0], prior bit}, and set i_sel_node to the final encoder state. Required: o_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Backpressure: hold en_tb high continuously for 3 frames. Required: exactly 16 accepts per frame, o_ready low for 32 cycles after each 16th accept, and the 3 frames decoded back-to-back with no drops.
- Gapped input: en_tb toggles 1-0-1-0 during WRITE. Required: only the high cycles are stored, i_sel_node is sampled only on the 16th accept, and the output equals the gap-free case.
- Ignored input: drive en_tb=1 with random columns during TRACE/OUT. Required: the decoded frame is unchanged, and the next frame starts at wr_cnt=0.
